// File: rtl/vdp1_ccalc_pipe.sv
// vdp1_ccalc_pipe -- VDP1 colour-calculation stage.
//
// Buffers pixels from the sprite/polygon generator in a small FIFO, fetches
// the background framebuffer word for modes that blend with it, applies
// shadow / half-luminance / half-transparency / Gouraud, and emits in-order
// framebuffer writes through a single output register.
//
// Optional feature macro: VDP1_GOURAUD_EN
//   defined   -> Gouraud clamp adders built, CCB[2] honoured.
//   undefined -> CCB[2] treated as 0, in_gouraud ignored.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready                pixel handshake
//   in_addr, in_color, in_gouraud,   destination address, {MSB,B,G,R} pixel,
//   in_ccb                           {B,G,R} Gouraud (16 neutral), mode
//   fb_rd_req/fb_rd_addr/fb_rd_ack   background read request (held to ack)
//   fb_rd_valid/fb_rd_data           in-order read return
//   out_valid/out_ready/out_addr/    framebuffer write
//   out_data
//   busy                             anything in flight

module vdp1_ccalc_pipe #(
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [15:0]       in_color,
  input  logic [14:0]       in_gouraud,
  input  logic [2:0]        in_ccb,
  output logic              fb_rd_req,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic              fb_rd_ack,
  input  logic              fb_rd_valid,
  input  logic [15:0]       fb_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_data,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       color;
    logic [14:0]       gour;
    logic [2:0]        ccb;
    logic [15:0]       back;
    logic              req;   // background read has been acked
    logic              fill;  // background data has arrived
  } ent_t;

  ent_t              fifo [DEPTH];
  logic [DEPTH-1:0]  occ;
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt, outst;
  logic              live;
  logic              ovld;
  logic [ADDR_W-1:0] oaddr;
  logic [15:0]       odata;

  logic              full, hazard, push, pop, head_ok;
  logic              rq_hit, rd_iss, rd_ret;
  logic [AW-1:0]     rq_idx, fl_idx;
  logic [14:0]       og, cres;
  logic [15:0]       res;

  // Per-channel blend on already-Gouraud-adjusted original o and background b.
  function automatic logic [4:0] ccalc(input logic [4:0] o, input logic [4:0] b,
                                       input logic [1:0] m, input logic bmsb);
    logic [4:0] y;
    case (m)
      2'b00:   y = o;
      2'b01:   y = bmsb ? {1'b0, b[4:1]} : b;
      2'b10:   y = {1'b0, o[4:1]};
      default: y = bmsb ? ({1'b0, o[4:1]} + {1'b0, b[4:1]}) : o;
    endcase
    return y;
  endfunction

  assign full     = (cnt == CW'(DEPTH));
  assign in_ready = live & ~full & ~hazard;
  assign push     = in_valid & in_ready;
  assign head_ok  = occ[rptr] & (~fifo[rptr].ccb[0] | fifo[rptr].fill);
  assign pop      = head_ok & (~ovld | out_ready);
  assign rd_iss   = rq_hit & fb_rd_ack;
  // Returns with nothing outstanding (e.g. issued before a reset) are dropped.
  assign rd_ret   = fb_rd_valid & (outst != '0);

  // Oldest-first searches starting at the head. Lower offsets win.
  // The request target stays fixed until acked: newer entries are younger and
  // the target cannot retire while unfilled.
  always_comb begin
    logic [AW-1:0] k;
    k      = '0;
    rq_hit = 1'b0;
    rq_idx = '0;
    fl_idx = '0;
    hazard = ovld && (oaddr == in_addr);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      k = rptr + AW'(unsigned'(i));
      if (occ[k] && fifo[k].ccb[0] && !fifo[k].req) begin
        rq_hit = 1'b1;
        rq_idx = k;
      end
      if (occ[k] && fifo[k].req && !fifo[k].fill)
        fl_idx = k;
    end
    for (int i = 0; i < DEPTH; i++)
      if (occ[i] && (fifo[i].addr == in_addr)) hazard = 1'b1;
  end

  assign fb_rd_req  = rq_hit;
  assign fb_rd_addr = rq_hit ? fifo[rq_idx].addr : '0;

  // Colour datapath on the head entry.
  for (genvar c = 0; c < 3; c++) begin : g_ch
`ifdef VDP1_GOURAUD_EN
    logic signed [6:0] s;
    assign s = $signed({2'b00, fifo[rptr].color[5*c +: 5]})
             + $signed({2'b00, fifo[rptr].gour[5*c +: 5]}) - 7'sd16;
    assign og[5*c +: 5] = !fifo[rptr].ccb[2] ? fifo[rptr].color[5*c +: 5] :
                          s[6]               ? 5'd0 :
                          (s > 7'sd31)       ? 5'd31 : s[4:0];
`else
    assign og[5*c +: 5] = fifo[rptr].color[5*c +: 5];
`endif
    assign cres[5*c +: 5] = ccalc(og[5*c +: 5], fifo[rptr].back[5*c +: 5],
                                  fifo[rptr].ccb[1:0], fifo[rptr].back[15]);
  end

`ifndef VDP1_GOURAUD_EN
  logic unused_gour;
  assign unused_gour = ^{fifo[rptr].gour, fifo[rptr].ccb[2]};
`endif

  // Shadow mode takes its MSB from the background; all others keep the original.
  assign res = {(fifo[rptr].ccb[1:0] == 2'b01) ? fifo[rptr].back[15] : fifo[rptr].color[15], cres};

  // Control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      outst <= '0;
      live  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) begin
        occ[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        occ[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      cnt   <= cnt + CW'(push) - CW'(pop);
      outst <= outst + CW'(rd_iss) - CW'(rd_ret);
    end
  end

  // Payload; validity is carried by occ, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push)
      fifo[wptr] <= '{addr: in_addr, color: in_color, gour: in_gouraud, ccb: in_ccb,
                      back: 16'h0, req: 1'b0, fill: 1'b0};
    if (rd_iss)
      fifo[rq_idx].req <= 1'b1;
    if (rd_ret) begin
      fifo[fl_idx].back <= fb_rd_data;
      fifo[fl_idx].fill <= 1'b1;
    end
  end

  // Output register; holds address/data while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovld  <= 1'b0;
      oaddr <= '0;
      odata <= '0;
    end else if (pop) begin
      ovld  <= 1'b1;
      oaddr <= fifo[rptr].addr;
      odata <= res;
    end else if (out_ready) begin
      ovld  <= 1'b0;
    end
  end

  assign out_valid = ovld;
  assign out_addr  = oaddr;
  assign out_data  = odata;
  assign busy      = (cnt != '0) | (outst != '0) | ovld;

endmodule
